// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the fetch/prefetch slice.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN    = 32;
    localparam int unsigned FETCH_DEPTH   = 4;
    localparam int unsigned FETCH_PC_STEP = 4;
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = '0;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory read port and decode-side handshake of the prefetch unit.
interface fetch_prefetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = FETCH_XLEN
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [XLEN-1:0] dec_instr_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_pc8_o;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr, dec_valid_o, dec_instr_o, dec_pc_o, dec_pc8_o,
        input  imem_rdata, dec_ready_i
    );

    // Memory / decode environment side.
    modport slave (
        input  imem_req, imem_addr, dec_valid_o, dec_instr_o, dec_pc_o, dec_pc8_o,
        output imem_rdata, dec_ready_i
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO: wrap-around pointers plus an explicit entry count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic            pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // Storage and pointers; flush drops everything, a same-cycle push included.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_entry;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop_ok);
        end
    end

    assign head       = mem_q[rptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential PC generator with a DEPTH-entry prefetch queue feeding decode.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
    parameter int unsigned     PC_STEP  = FETCH_PC_STEP
) (
    input  logic                   CLK,
    input  logic                   RST,
    fetch_prefetch_unit_if.master  bus,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    entry_t          push_entry;
    entry_t          head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ_sum;

    // A request reserves its queue slot at issue, so a full queue can still
    // accept the response in the same cycle it pops.
    assign occ_sum    = count + CW'(inflight_q);
    assign issue      = !RST && !redirect_i && (occ_sum < CW'(DEPTH));
    assign push       = inflight_q && !redirect_i;
    assign pop        = head_valid && bus.dec_ready_i;
    assign push_entry = {req_pc_q, bus.imem_rdata};

    // Fetch PC and in-flight tracking; redirect overrides sequential advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect_i) begin
                fetch_pc_q <= redirect_pc_i;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
            end
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_i),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.dec_valid_o = head_valid;
    assign bus.dec_instr_o = head.instr;
    assign bus.dec_pc_o    = head.pc;
    assign bus.dec_pc8_o   = head.pc + XLEN'(2 * PC_STEP);
    assign occupancy_o     = count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: directed scenarios push expected {pc, instr}; monitors
// pop and compare on every decode handshake.
module tb_fetch_prefetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [2:0]  occ;
    logic [2:0]  occ_w;

    int total = 0;
    int bad = 0;
    int nreq;

    exp_t exp_q[$];
    exp_t expw_q[$];

    fetch_prefetch_unit_if #(.XLEN(32)) bus ();
    fetch_prefetch_unit_if #(.XLEN(32)) bus_w ();

    fetch_prefetch_unit #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .occupancy_o(occ)
    );

    fetch_prefetch_unit #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
    ) dut_wrap (
        .CLK(clk), .RST(rst_w), .bus(bus_w), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .occupancy_o(occ_w)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word index of the address.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
        if (bus_w.imem_req) bus_w.imem_rdata <= bus_w.imem_addr >> 2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        mk = {pc, pc >> 2};
    endfunction

    // Main DUT monitor.
    always @(negedge clk) begin
        if (bus.dec_valid_o === 1'b1 && bus.dec_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL hs_unexpected actual_pc=%h required=none", bus.dec_pc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hs_pc", bus.dec_pc_o, e.pc);
                chk("hs_instr", bus.dec_instr_o, e.instr);
                chk("hs_pc8", bus.dec_pc8_o, e.pc + 32'd8);
            end
        end
    end

    // Wrap-around DUT monitor.
    always @(negedge clk) begin
        if (bus_w.dec_valid_o === 1'b1 && bus_w.dec_ready_i === 1'b1) begin
            if (expw_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wrap_unexpected actual_pc=%h required=none", bus_w.dec_pc_o);
            end else begin
                exp_t e;
                e = expw_q.pop_front();
                chk("wrap_pc", bus_w.dec_pc_o, e.pc);
                chk("wrap_instr", bus_w.dec_instr_o, e.instr);
                chk("wrap_pc8", bus_w.dec_pc8_o, e.pc + 32'd8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reset for two edges; returns at the start of cycle 0 with ready low.
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        bus.dec_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.dec_ready_i = 1'b0;
        bus_w.dec_ready_i = 1'b0;
        repeat (3) tick();

        // Reset state.
        mid();
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", bus.dec_valid_o, 1'b0);
        chk("rst_instr", bus.dec_instr_o, 32'h0);
        chk("rst_pc", bus.dec_pc_o, 32'h0);
        chk("rst_pc8", bus.dec_pc8_o, 32'h8);
        chk("rst_occ", occ, 3'd0);
        chk("rst_wrap_addr", bus_w.imem_addr, 32'hFFFF_FFF8);
        chk("rst_wrap_pc8", bus_w.dec_pc8_o, 32'h8);

        // Streaming after reset, plus wrap-around instance.
        tick();
        rst = 1'b0;
        rst_w = 1'b0;
        bus.dec_ready_i = 1'b1;
        bus_w.dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(i * 4)));
        expw_q.push_back(mk(32'hFFFF_FFF8));
        expw_q.push_back(mk(32'hFFFF_FFFC));
        expw_q.push_back(mk(32'h0000_0000));
        expw_q.push_back(mk(32'h0000_0004));
        mid();
        chk("t1_c0_req", bus.imem_req, 1'b1);
        chk("t1_c0_addr", bus.imem_addr, 32'h0);
        tick();
        mid();
        chk("t1_c1_valid", bus.dec_valid_o, 1'b0);
        tick();
        mid();
        chk("t1_c2_valid", bus.dec_valid_o, 1'b1);
        repeat (4) tick();
        rst_w = 1'b1;
        bus_w.dec_ready_i = 1'b0;
        do_reset();

        // Stall from cycle 0: queue fills to DEPTH, then drains in order.
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            mid();
            if (bus.imem_req === 1'b1) nreq++;
            if (c == 2) begin
                chk("t2_c2_valid", bus.dec_valid_o, 1'b1);
                chk("t2_c2_pc", bus.dec_pc_o, 32'h0);
            end
            if (c == 9) begin
                chk("t2_full_occ", occ, 3'd4);
                chk("t2_full_req", bus.imem_req, 1'b0);
                chk("t2_head_pc", bus.dec_pc_o, 32'h0);
                chk("t2_head_instr", bus.dec_instr_o, 32'h0);
            end
            tick();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        bus.dec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4)));
        repeat (8) tick();
        bus.dec_ready_i = 1'b0;
        do_reset();

        // Redirect with three queued entries and one read in flight.
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h100 + 32'(i * 4)));
        tick();
        tick();
        bus.dec_ready_i = 1'b1;
        tick();
        tick();
        bus.dec_ready_i = 1'b0;
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        mid();
        chk("t3_c6_occ", occ, 3'd3);
        chk("t3_c6_req", bus.imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        mid();
        chk("t3_c7_valid", bus.dec_valid_o, 1'b0);
        chk("t3_c7_occ", occ, 3'd0);
        chk("t3_c7_req", bus.imem_req, 1'b1);
        chk("t3_c7_addr", bus.imem_addr, 32'h100);
        tick();
        mid();
        chk("t3_c8_valid", bus.dec_valid_o, 1'b0);
        chk("t3_c8_addr", bus.imem_addr, 32'h104);
        tick();
        bus.dec_ready_i = 1'b1;
        mid();
        chk("t3_c9_valid", bus.dec_valid_o, 1'b1);
        repeat (4) tick();
        bus.dec_ready_i = 1'b0;
        do_reset();

        // Redirect coincident with the handshake on head 0x10.
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'(i * 4)));
        exp_q.push_back(mk(32'h200));
        exp_q.push_back(mk(32'h204));
        bus.dec_ready_i = 1'b1;
        repeat (6) tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        mid();
        chk("t4_c6_pc", bus.dec_pc_o, 32'h10);
        tick();
        redirect = 1'b0;
        mid();
        chk("t4_c7_valid", bus.dec_valid_o, 1'b0);
        tick();
        mid();
        chk("t4_c8_valid", bus.dec_valid_o, 1'b0);
        tick();
        mid();
        chk("t4_c9_valid", bus.dec_valid_o, 1'b1);
        tick();
        tick();
        bus.dec_ready_i = 1'b0;
        do_reset();

        // Reset asserted in cycle 5 with a full queue.
        repeat (5) tick();
        rst = 1'b1;
        mid();
        chk("t6_c5_req", bus.imem_req, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        mid();
        chk("t6_valid", bus.dec_valid_o, 1'b0);
        chk("t6_occ", occ, 3'd0);
        chk("t6_pc", bus.dec_pc_o, 32'h0);
        chk("t6_instr", bus.dec_instr_o, 32'h0);
        chk("t6_pc8", bus.dec_pc8_o, 32'h8);
        chk("t6_req", bus.imem_req, 1'b1);
        chk("t6_addr", bus.imem_addr, 32'h0);
        bus.dec_ready_i = 1'b1;
        repeat (4) tick();
        bus.dec_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("sb_wrap_drain", 32'(expw_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised successor of the single-cycle fetch stage. It generates the sequential PC stream, issues reads to a synchronous instruction memory, and buffers returned instructions in a DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. A redirect port carries branch and PC-write targets: it flushes the queue and drops in-flight reads. The block sits between the instruction memory and the decode stage of the pipelined CPU.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.
- PC_STEP, 4: byte increment between sequential fetches.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  read address (current fetch PC).
- imem_rdata  in  XLEN  read data, valid exactly one cycle after a request.
- redirect_i  in  1  take redirect this cycle.
- redirect_pc_i  in  XLEN  redirect target.
- dec_valid_o  out  1  queue head valid.
- dec_ready_i  in  1  decode accepts head.
- dec_instr_o  out  XLEN  head instruction.
- dec_pc_o  out  XLEN  head PC.
- dec_pc8_o  out  XLEN  head PC + 2·PC_STEP (R15 read value).
- occupancy_o  out  $clog2(DEPTH)+1  queue entry count.

## Operation
- fetch_pc register: reset value RESET_PC. Advances by PC_STEP on each issued request. Loaded with redirect_pc_i on redirect. Arithmetic is modulo 2^XLEN, so 0xFFFF_FFFC+4 = 0.
- Issue rule: imem_req = !RST && !redirect_i && (occupancy + inflight < DEPTH). inflight is a 1-bit register set when a request issues.
- Response capture: when inflight=1 and no kill, {pc_of_request, imem_rdata} is pushed at the queue tail. pc_of_request is registered alongside inflight.
- Pop: dec_valid_o && dec_ready_i removes the head. Push and pop in the same cycle are both allowed, including when full, because the push slot was reserved at issue.
- Redirect (priority over all else):
  - A handshake in the same cycle completes first (it counts).
  - The queue is cleared at the edge, and occupancy becomes 0.
  - Any response arriving in the redirect cycle is discarded.
  - fetch_pc ← redirect_pc_i; the first new request issues the next cycle.
- Back-to-back redirects: the last one wins, and no request issues until the first cycle without redirect.
- Stall: dec_ready_i=0 holds the head stable, with dec_* outputs unchanged. Fetch continues until occupancy+inflight = DEPTH, then imem_req=0.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - dec_valid_o=0; dec_instr_o, dec_pc_o = 0; dec_pc8_o = 2·PC_STEP.
  - occupancy_o=0, inflight=0.
- Reset mid-operation: same cycle it is sampled, all state returns to the reset values, and the pending response is discarded.

## Timing
- Cycle 0 = first cycle with RST low: imem_req=1, addr RESET_PC.
- Cycle 1: data is returned and pushed at the edge.
- Cycle 2: dec_valid_o=1. Fetch-to-decode latency is 2 cycles.
- Steady state with dec_ready_i=1: one instruction per cycle, consecutive PCs.
- Redirect in cycle k:
  - Request at redirect_pc in cycle k+1.
  - dec_valid_o=1 with dec_pc_o=redirect_pc in cycle k+3.
  - dec_valid_o=0 in k+1 and k+2.
- Outputs dec_* come from registers or the queue head only; there is no combinational path from imem_rdata to dec_*.
- dec_ready_i affects only pop and issue; it never combinationally drives dec_valid_o.

## Structure
- Shared package (fetch_pkg): fetch_entry_t struct {pc, instr} (XLEN each), the DEPTH/PC_STEP defaults, and the RESET_PC constant.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, head, count. It uses wrap-around read/write pointers of $clog2(DEPTH) bits plus the count.
- Top level: fetch_pc, inflight/kill logic, issue rule, and the PC+8 adder.

## Test plan
- Reset release, dec_ready_i=1, imem returns addr>>2: dec_pc_o = 0, 4, 8, 12 in cycles 2–5, dec_pc8_o = 8, 12, 16, 20, valid every cycle.
- dec_ready_i=0 from cycle 0, DEPTH=4:
  - Exactly 4 requests issue, occupancy_o=4, imem_req=0 thereafter.
  - Head stays PC 0.
  - Releasing ready resumes one instruction per cycle, with no loss or duplicate.
- Redirect to 0x100 in cycle 6 with queue at 3 and a request in flight:
  - Queue empties and the stale response is dropped.
  - Next dec_pc_o = 0x100 in cycle 9, then 0x104.
- Redirect coincident with a handshake on head PC 0x10:
  - 0x10 counts as consumed exactly once.
  - Next delivered PC = redirect target.
- RESET_PC = 0xFFFF_FFF8: delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; dec_pc8_o wraps to 0x0, 0x4, 0x8, 0xC.
- RST asserted in cycle 5 with a full queue: next cycle, all outputs are at reset values; after release, refetch starts at RESET_PC.
